// File: rtl/dda_run_ctrl.sv
// Run controller for a Q(N).(M) forward-Euler integrator of dy/dt = k*y.
// Sequences n_steps MUL/INT/EMIT rounds and streams (t, y) over valid/ready.
module dda_run_ctrl #(
  parameter int N          = 16,
  parameter int M          = 16,
  parameter int STEP_SHIFT = 9,
  parameter int CNT_W      = 16,
  localparam int W         = N + M
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_steps,
  input  logic [W-1:0]     y0,
  input  logic [W-1:0]     k,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_t,
  output logic [W-1:0]     out_y
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_INT,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [W-1:0] T_INC = W'(1) << (M - STEP_SHIFT);

  state_t                state;
  logic [CNT_W-1:0]      n_lat;
  logic [CNT_W-1:0]      cnt;
  logic signed [W-1:0]   k_reg;
  logic signed [W-1:0]   y;
  logic signed [W-1:0]   dy_reg;
  logic [W-1:0]          t;

  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] prod_sh;
  logic                  sat_pos;
  logic                  sat_neg;
  logic signed [W-1:0]   dy_sat;
  logic signed [W-1:0]   y_next;

  // Saturate when the shifted product does not fit: bits above W-1 must all match the sign.
  assign prod    = (2*W)'(k_reg) * (2*W)'(y);
  assign prod_sh = prod >>> M;
  assign sat_pos = !prod_sh[2*W-1] && (|prod_sh[2*W-2:W-1]);
  assign sat_neg =  prod_sh[2*W-1] && !(&prod_sh[2*W-2:W-1]);
  assign dy_sat  = sat_pos ? {1'b0, {(W-1){1'b1}}} :
                   sat_neg ? {1'b1, {(W-1){1'b0}}} : prod_sh[W-1:0];
  assign y_next  = y + (dy_reg >>> STEP_SHIFT);

  assign out_t = t;
  assign out_y = y;

  // NOTE: every register here uses <= so all updates see pre-edge values, like real flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      n_lat     <= '0;
      cnt       <= '0;
      k_reg     <= '0;
      y         <= '0;
      dy_reg    <= '0;
      t         <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              n_lat <= n_steps;
              k_reg <= k;
              y     <= y0;
              t     <= '0;
              cnt   <= '0;
              ovf   <= 1'b0;
              busy  <= 1'b1;
              if (n_steps == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_MUL;
              end
            end
          end
          S_MUL: begin
            dy_reg <= dy_sat;
            if (sat_pos || sat_neg) ovf <= 1'b1;
            state  <= S_INT;
          end
          S_INT: begin
            y         <= y_next;
            t         <= t + T_INC;
            cnt       <= cnt + CNT_W'(1);
            out_valid <= 1'b1;
            state     <= S_EMIT;
          end
          S_EMIT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (cnt == n_lat) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_MUL;
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dda_run_ctrl.sv
// Self-checking bench for dda_run_ctrl: a Q16.16 Euler model fills a sample
// queue at start; samples are popped and compared at each handshake.
module tb_dda_run_ctrl;

  typedef struct packed {
    logic [31:0] t;
    logic [31:0] y;
  } sample_t;

  localparam longint SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint SAT_MIN = -64'sh0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] n_steps;
  logic [31:0] y0;
  logic [31:0] k;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_t;
  logic [31:0] out_y;

  sample_t exp_q[$];
  int      tests = 0;
  int      fails = 0;

  dda_run_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .n_steps   (n_steps),
    .y0        (y0),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_t     (out_t),
    .out_y     (out_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference Euler model: pushes every expected sample and reports saturation.
  task automatic model_push(input logic [31:0] y0v, input logic [31:0] kv, input int n,
                            output bit ov);
    logic [31:0] tt;
    logic [31:0] yy;
    tt = '0;
    yy = y0v;
    ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      longint p;
      longint d;
      logic signed [31:0] dy;
      p = longint'($signed(kv)) * longint'($signed(yy));
      d = p >>> 16;
      if (d > SAT_MAX) begin
        dy = 32'sh7FFF_FFFF;
        ov = 1'b1;
      end else if (d < SAT_MIN) begin
        dy = 32'sh8000_0000;
        ov = 1'b1;
      end else begin
        dy = d[31:0];
      end
      yy = yy + 32'(dy >>> 9);
      tt = tt + 32'h80;
      exp_q.push_back('{t: tt, y: yy});
    end
  endtask

  task automatic pulse_start(input logic [31:0] y0v, input logic [31:0] kv, input int n);
    @(posedge clk);
    #1;
    start   = 1'b1;
    n_steps = 16'(n);
    y0      = y0v;
    k       = kv;
    @(posedge clk);
    #1;
    start   = 1'b0;
    n_steps = 16'($urandom);
    y0      = $urandom;
    k       = $urandom;
  endtask

  task automatic run_case(input string name, input logic [31:0] y0v, input logic [31:0] kv,
                          input int n, input bit rnd);
    bit          exp_ovf;
    bit          prev_pend;
    int          first_v;
    int          done_c;
    int          done_cnt;
    int          samples;
    int          budget;
    logic [31:0] pt;
    logic [31:0] py;
    sample_t     s;
    model_push(y0v, kv, n, exp_ovf);
    out_ready = 1'b1;
    pulse_start(y0v, kv, n);
    first_v   = -1;
    done_c    = -1;
    done_cnt  = 0;
    samples   = 0;
    prev_pend = 1'b0;
    pt        = '0;
    py        = '0;
    budget    = rnd ? 20 * n + 20 : 3 * n + 20;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
        start     = out_valid && ($urandom_range(0, 1) == 1);
      end
      if (c == 0) begin
        check({name, "_busy_after_start"}, busy, 1);
        check({name, "_ovf_cleared"}, ovf, 0);
      end
      if (out_valid && first_v < 0) first_v = c;
      if (prev_pend) begin
        check({name, "_hold_valid"}, out_valid, 1);
        check({name, "_hold_t"}, out_t, pt);
        check({name, "_hold_y"}, out_y, py);
      end
      if (done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      if (out_valid && out_ready) begin
        samples++;
        if (exp_q.size() == 0) begin
          check({name, "_extra_sample"}, 1, 0);
        end else begin
          s = exp_q.pop_front();
          check({name, "_t"}, out_t, s.t);
          check({name, "_y"}, out_y, s.y);
        end
      end
      prev_pend = out_valid && !out_ready;
      pt        = out_t;
      py        = out_y;
      if (done_c >= 0 && c > done_c) break;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check({name, "_done_seen"}, done_c >= 0, 1);
    check({name, "_done_width"}, done_cnt, 1);
    check({name, "_samples"}, samples, n);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_busy_idle"}, busy, 0);
    check({name, "_ovf"}, ovf, exp_ovf);
    if (!rnd) begin
      check({name, "_done_cycle"}, done_c, (n == 0) ? 0 : 3 * n);
      check({name, "_first_valid"}, first_v, (n == 0) ? -1 : 2);
    end
    exp_q.delete();
  endtask

  task automatic abort_case();
    bit      ov;
    bit      seen;
    bit      bad;
    sample_t s;
    model_push(32'h7FFF_0000, 32'h7FFF_0000, 3, ov);
    out_ready = 1'b1;
    pulse_start(32'h7FFF_0000, 32'h7FFF_0000, 3);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_reach_emit", seen, 1);
    s = exp_q.pop_front();
    check("abort_first_y", out_y, s.y);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ovf_kept", ovf, ov);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || out_valid || busy) bad = 1'b1;
    end
    check("abort_quiet", bad, 0);
    exp_q.delete();
  endtask

  task automatic reset_case();
    out_ready = 1'b1;
    pulse_start(32'h0001_0000, 32'h0001_0000, 4);
    @(negedge clk);
    check("rst_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_out_y", out_y, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stay_idle", {busy, out_valid, done}, 3'b000);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    n_steps   = '0;
    y0        = '0;
    k         = '0;
    #1;
    check("reset_state", {busy, done, ovf, out_valid}, 4'b0000);
    check("reset_t", out_t, 0);
    check("reset_y", out_y, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_case("unit_k", 32'h0001_0000, 32'h0001_0000, 2, 1'b0);
    check("unit_k_last_y", out_y, 32'h0001_0100);
    check("unit_k_last_t", out_t, 32'h0000_0100);
    run_case("neg_k", 32'h0001_0000, 32'hFFFF_0000, 1, 1'b0);
    check("neg_k_y", out_y, 32'h0000_FF80);
    run_case("sat", 32'h7FFF_0000, 32'h7FFF_0000, 1, 1'b0);
    check("sat_y", out_y, 32'h803E_FFFF);
    check("sat_ovf", ovf, 1);
    run_case("bp", 32'h1234_5678, 32'h0000_8000, 3, 1'b1);
    run_case("bp_neg", 32'hFFF0_0000, 32'hFFFE_8000, 5, 1'b1);
    run_case("zero", 32'h0001_0000, 32'h0001_0000, 0, 1'b0);
    run_case("long", 32'h0001_0000, 32'h0001_0000, 512, 1'b0);
    check("long_last_t", out_t, 32'h0001_0000);
    abort_case();
    reset_case();
    run_case("after_rst", 32'h0002_0000, 32'hFFFF_8000, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
